// File: rtl/rapids_lsu_pkg.sv
// Shared encodings for the load/store unit.
// Size codes, fault codes and FSM states.
package rapids_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_SEGV     = 2'd2;
  localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WRITE,
    RESP
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract and merge for
// sub-word loads and read-modify-write stores.
module lsu_lane_align
  import rapids_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] value_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // select the addressed lane, extend it, and splice store data in
  always_comb begin
    byte_v   = word_i[{off_i, 3'b000} +: 8];
    half_v   = off_i[1] ? word_i[31:16] : word_i[15:0];
    value_o  = word_i;
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        value_o = {{24{sgn_i & byte_v[7]}}, byte_v};
        merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        value_o = {{16{sgn_i & half_v[15]}}, half_v};
        if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else          merged_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for the word-wide MMU
// data port; sub-word stores use read-modify-write.
module load_store_unit
  import rapids_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wait,
  input  logic        mem_segv
);

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] cnt_nxt;
  logic        timed_out;
  logic        wstore;
  logic [31:0] ext_v;
  logic [31:0] merged_v;

  assign cnt_nxt   = cnt_q + 32'd1;
  assign timed_out = (TIMEOUT != 0) &&
                     (cnt_nxt >= 32'(TIMEOUT));
  assign wstore    = store_q && (size_q == SZ_WORD);

  lsu_lane_align u_align (
    .word_i   (mem_rdata),
    .off_i    (addr_q[1:0]),
    .size_i   (size_q),
    .sgn_i    (sgn_q),
    .wdata_i  (wdata_q),
    .value_o  (ext_v),
    .merged_o (merged_v)
  );

  // state and latched request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= FLT_NONE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state, strobes and response
  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_fault = FLT_NONE;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_rd     = 1'b0;
    mem_wd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          cnt_d   = 32'd0;
          if (misaligned(req_size, req_addr[1:0])) begin
            fault_d = FLT_MISALIGN;
            state_d = RESP;
          end else begin
            fault_d = FLT_NONE;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_addr = {2'b00, addr_q[31:2]};
        if (mem_segv) begin
          fault_d = FLT_SEGV;
          state_d = RESP;
        end else begin
          if (wstore) begin
            mem_wd    = 1'b1;
            mem_wdata = wdata_q;
          end else begin
            mem_rd = 1'b1;
          end
          if (mem_wait) begin
            cnt_d = cnt_nxt;
            if (timed_out) begin
              fault_d = FLT_TIMEOUT;
              state_d = RESP;
            end
          end else if (wstore) begin
            state_d = RESP;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        mem_addr = {2'b00, addr_q[31:2]};
        if (store_q) begin
          word_d  = merged_v;
          cnt_d   = 32'd0;
          state_d = WRITE;
        end else begin
          rdata_d = ext_v;
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_addr = {2'b00, addr_q[31:2]};
        if (mem_segv) begin
          fault_d = FLT_SEGV;
          state_d = RESP;
        end else begin
          mem_wd    = 1'b1;
          mem_wdata = word_q;
          if (mem_wait) begin
            cnt_d = cnt_nxt;
            if (timed_out) begin
              fault_d = FLT_TIMEOUT;
              state_d = RESP;
            end
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_fault = fault_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a
// small behavioural MMU model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wd;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_wait;
  logic        mem_segv;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wd     (mem_wd),
    .mem_rdata  (mem_rdata),
    .mem_wait   (mem_wait),
    .mem_segv   (mem_segv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          t_acc;
    int          lat;
    int          rd;
    int          wd;
    logic [31:0] maddr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [31:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a = 8'd0;
  logic [31:0] pre_d = 32'd0;
  int          wait_req = 0;
  int          wait_used = 0;
  logic        stuck = 1'b0;

  assign mem_segv = (mem_addr == 32'd0) || (mem_addr >= 32'd128);
  assign mem_wait = (mem_rd || mem_wd) &&
                    (stuck || (wait_used < wait_req));

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // MMU model: registered read data, gated write
  always @(posedge clk) begin
    if (pre_we)
      mem[pre_a] <= pre_d;
    else if (mem_wd && !mem_wait && !mem_segv)
      mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_rd && !mem_wait)
      mem_rdata <= mem[mem_addr[7:0]];
    if (resp_valid)
      wait_used <= 0;
    else if (mem_wait)
      wait_used <= wait_used + 1;
  end

  int          rd_c = 0;
  int          wd_c = 0;
  logic [31:0] last_a = 32'd0;

  // monitor: count strobes, pop and compare responses
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_c = 0;
      wd_c = 0;
    end else begin
      if (mem_rd && mem_wd)
        chk("rd_wd_exclusive", 32'd1, 32'd0);
      if (mem_rd) rd_c++;
      if (mem_wd) wd_c++;
      if (mem_rd || mem_wd) last_a = mem_addr;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("fault", 32'(resp_fault), 32'(e.fault));
          chk("latency", 32'(cyc - e.t_acc), 32'(e.lat));
          chk("rd_cycles", 32'(rd_c), 32'(e.rd));
          chk("wd_cycles", 32'(wd_c), 32'(e.wd));
          if (e.rd + e.wd > 0)
            chk("mem_addr", last_a, e.maddr);
        end
        rd_c = 0;
        wd_c = 0;
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_req(
    input logic st, input logic [1:0] sz, input logic sg,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] er, input logic [1:0] ef,
    input int el, input int erd, input int ewd
  );
    exp_t e;
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    e.rdata = er;
    e.fault = ef;
    e.t_acc = cyc;
    e.lat   = el;
    e.rd    = erd;
    e.wd    = ewd;
    e.maddr = a >> 2;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    preload(8'd16, 32'h0);
    preload(8'd17, 32'h55667788);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wd", 32'(mem_wd), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_req(1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 32'h0, 2'd0, 2, 0, 1);
    do_req(0, 2'd2, 0, 32'h40, 32'h0, 32'hDEADBEEF, 2'd0, 3, 1, 0);
    do_req(1, 2'd2, 0, 32'h40, 32'h11223344, 32'h0, 2'd0, 2, 0, 1);
    do_req(1, 2'd0, 0, 32'h41, 32'h000000AA, 32'h0, 2'd0, 4, 1, 1);
    chk("mem_after_byte_store", mem[16], 32'h1122AA44);
    do_req(0, 2'd0, 1, 32'h41, 32'h0, 32'hFFFFFFAA, 2'd0, 3, 1, 0);
    do_req(0, 2'd0, 0, 32'h41, 32'h0, 32'h000000AA, 2'd0, 3, 1, 0);
    do_req(0, 2'd1, 0, 32'h42, 32'h0, 32'h00001122, 2'd0, 3, 1, 0);
    do_req(0, 2'd1, 1, 32'h40, 32'h0, 32'hFFFFAA44, 2'd0, 3, 1, 0);
    do_req(1, 2'd1, 0, 32'h42, 32'h1234BEEF, 32'h0, 2'd0, 4, 1, 1);
    chk("mem_after_half_store", mem[16], 32'hBEEFAA44);
    do_req(0, 2'd0, 1, 32'h43, 32'h0, 32'hFFFFFFBE, 2'd0, 3, 1, 0);

    do_req(0, 2'd1, 0, 32'h43, 32'h0, 32'h0, 2'd1, 1, 0, 0);
    do_req(0, 2'd2, 0, 32'h42, 32'h0, 32'h0, 2'd1, 1, 0, 0);
    do_req(0, 2'd3, 0, 32'h40, 32'h0, 32'h0, 2'd1, 1, 0, 0);

    do_req(0, 2'd2, 0, 32'h0, 32'h0, 32'h0, 2'd2, 2, 0, 0);
    do_req(1, 2'd2, 0, 32'h240, 32'h12345678, 32'h0, 2'd2, 2, 0, 0);
    do_req(1, 2'd0, 0, 32'h241, 32'h00000055, 32'h0, 2'd2, 2, 0, 0);

    wait_req = 3;
    do_req(0, 2'd2, 0, 32'h40, 32'h0, 32'hBEEFAA44, 2'd0, 6, 4, 0);
    wait_req = 0;
    stuck = 1'b1;
    do_req(0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 2'd3, 5, 4, 0);
    stuck = 1'b0;
    do_req(0, 2'd2, 0, 32'h40, 32'h0, 32'hBEEFAA44, 2'd0, 3, 1, 0);

    // reset while the merged word is being written
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h44;
    req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_wd && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wd_seen_before_reset", 32'(mem_wd), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_mem_wd", 32'(mem_wd), 32'd0);
    chk("rst_mid_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("mem_unmodified", mem[17], 32'h55667788);
    do_req(0, 2'd2, 0, 32'h44, 32'h0, 32'h55667788, 2'd0, 3, 1, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the MMU data port. Accepts one load/store request at a time from the execute stage and converts byte addresses to the MMU's word addresses.
- Drives the MMU's rd/wd/address/data strobes, honours its wait and segv signals, and returns one response per request.
- The MMU is word-wide, so byte and halfword stores use read-modify-write. Loads are extracted little-endian, with optional sign extension.

Parameters:
- TIMEOUT, 16: maximum consecutive cycles mem_wait may stay high before the access is aborted. 0 disables the timeout.

Ports:
- clk  in  1  clock. One clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result. 0 for stores and faults.
- resp_fault  out  2  0 = none, 1 = misaligned, 2 = segv, 3 = timeout.
- mem_addr  out  32  word address, equal to req_addr >> 2 (zero-filled).
- mem_wdata  out  32  word to write.
- mem_rd  out  1  MMU read enable.
- mem_wd  out  1  MMU write enable.
- mem_rdata  in  32  MMU read data, registered by the MMU.
- mem_wait  in  1  MMU not ready; hold the strobes.
- mem_segv  in  1  combinational fault for mem_addr.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except req_ready = 1.
  - Latched request and timeout counter are cleared.
  - A reset mid-access drops mem_rd/mem_wd immediately; a partial read-modify-write leaves memory unmodified.
- IDLE:
  - req_ready = 1.
  - When req_valid = 1 at the edge, latch the request.
  - Misaligned if size = 3, or half with addr[0] = 1, or word with addr[1:0] != 0. A misaligned request goes to RESP with fault 1.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_addr is driven from the latched address.
  - If mem_segv = 1: no strobe is asserted; go to RESP with fault 2.
  - Load or sub-word store: mem_rd = 1. Word store: mem_wd = 1 and mem_wdata = req_wdata.
  - If mem_wait = 1: hold the strobes and increment the counter. When the counter reaches TIMEOUT, go to RESP with fault 3.
  - If mem_wait = 0: a read goes to CAPTURE; a word store goes to RESP with fault 0.
- CAPTURE:
  - Sample mem_rdata into the word register. No strobes.
  - Load: extract the lane selected by addr[1:0] (byte lane = addr[1:0], half lane = addr[1]), zero- or sign-extend, then go to RESP.
  - Sub-word store: merge req_wdata[7:0] or [15:0] into that lane, then go to WRITE.
- WRITE:
  - mem_wd = 1, mem_wdata = merged word, same mem_addr.
  - Wait and timeout handling is as in ISSUE; the counter resets on entry.
  - When mem_wait = 0, go to RESP.
  - mem_segv is re-checked here; if set, go to RESP with fault 2 and do not write.
- RESP:
  - resp_valid = 1 for exactly one cycle, with rdata/fault held.
  - Go to IDLE. No backpressure on responses.
- Latency from the accept edge to the resp_valid cycle, with zero wait:
  - word store: 2
  - load: 3
  - sub-word store: 4
  - misaligned: 1
  - segv: 2
- mem_rd and mem_wd are never high in the same cycle.

Decomposition:
- Package rapids_lsu_pkg holds:
  - the size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the fault codes (FLT_NONE, FLT_MISALIGN, FLT_SEGV, FLT_TIMEOUT)
  - the state encoding (IDLE, ISSUE, CAPTURE, WRITE, RESP)
- Sub-module lsu_lane_align, combinational:
  - extract: word, offset, size, signed → value
  - merge: word, offset, size, wdata → word

Test Plan:
1. Word store, then load:
   - Store addr 0x40, data 0xDEADBEEF, size 2 → mem_addr = 16, mem_wd for one cycle, resp fault 0 two cycles after accept.
   - Load word from 0x40 → rdata 0xDEADBEEF.
2. Sub-word store and signed byte load:
   - Memory at word 16 = 0x11223344. Store byte 0xAA to 0x41 → read then write 0x1122AA44.
   - Load signed byte from 0x41 → 0xFFFFFFAA. Unsigned → 0x000000AA.
3. Halfword load and misaligned requests:
   - Halfword load from 0x42 on word 0x1122AA44 → 0x00001122.
   - Halfword at 0x43 → fault 1 one cycle after accept, no mem strobes.
   - Word at 0x42 → fault 1.
4. Segv:
   - Load from 0x0 (word 0) → fault 2, mem_rd never high.
   - Store to 0x240 (word 144) → fault 2, no write.
5. Wait and timeout:
   - mem_wait held 3 cycles on a load → strobes held steady, response 6 cycles after accept.
   - TIMEOUT = 4 with mem_wait stuck at 1 → fault 3, strobes drop, unit returns to IDLE.
6. Reset in WRITE:
   - Assert reset while mem_wd = 1 → mem_wd drops the same cycle, req_ready = 1, resp_valid = 0.
   - Subsequent load sees the original word.
